// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter slice.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADR_WIDTH  = 5;

  localparam int REG_ZERO     = 0;
  localparam int REG_IRQ_VIEW = 4;

  typedef struct packed {
    logic [DEF_ADR_WIDTH-1:0]  addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant with a single pointer flop (0 = A has priority).
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic ptr_b;

  // Grants are forced low while reset is held so no handshake completes.
  always_comb begin
    gnt_a_o = rst_ni & req_a_i & (~req_b_i | ~ptr_b);
    gnt_b_o = rst_ni & req_b_i & (~req_a_i |  ptr_b);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_b <= 1'b0;
    end else if (gnt_a_o) begin
      ptr_b <= 1'b1;
    end else if (gnt_b_o) begin
      ptr_b <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU (A) and load (B) writeback,
// with a registered output stage and a busy-bit scoreboard for hazard stalls.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADR_WIDTH  = DEF_ADR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [ADR_WIDTH-1:0]  a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic [ADR_WIDTH-1:0]  b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  input  logic                  mark_i,
  input  logic [ADR_WIDTH-1:0]  mark_addr_i,
  input  logic [ADR_WIDTH-1:0]  q1_addr_i,
  input  logic [ADR_WIDTH-1:0]  q2_addr_i,
  output logic                  busy1_o,
  output logic                  busy2_o,
  output logic                  we3_o,
  output logic [ADR_WIDTH-1:0]  a3_o,
  output logic [DATA_WIDTH-1:0] wd3_o,
  output logic                  idle_o
);

  localparam int NREG = 2 ** ADR_WIDTH;
  localparam logic [ADR_WIDTH-1:0] ADDR_ZERO = ADR_WIDTH'(REG_ZERO);
  localparam logic [ADR_WIDTH-1:0] ADDR_IRQ  = ADR_WIDTH'(REG_IRQ_VIEW);

  typedef struct packed {
    logic [ADR_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  logic gnt_a, gnt_b;
  req_t sel_p0;

  logic                  we_p1;
  logic [ADR_WIDTH-1:0]  a3_p1;
  logic [DATA_WIDTH-1:0] wd_p1;

  logic [NREG-1:0] busy, busy_nxt;

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_a_i (a_valid_i),
    .req_b_i (b_valid_i),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  assign a_ready_o = gnt_a;
  assign b_ready_o = gnt_b;

  always_comb begin
    sel_p0 = gnt_b ? req_t'{addr: b_addr_i, data: b_data_i}
                   : req_t'{addr: a_addr_i, data: a_data_i};
  end

  // Stage p0 -> p1: accepted request becomes the regfile write next cycle.
  // x0 is accepted but never enabled; address/data hold when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_p1 <= 1'b0;
      a3_p1 <= '0;
      wd_p1 <= '0;
    end else if (gnt_a || gnt_b) begin
      we_p1 <= (sel_p0.addr != ADDR_ZERO);
      a3_p1 <= sel_p0.addr;
      wd_p1 <= sel_p0.data;
    end else begin
      we_p1 <= 1'b0;
    end
  end

  assign we3_o = we_p1;
  assign a3_o  = a3_p1;
  assign wd3_o = wd_p1;

  // Clear on the regfile commit edge, then set, so a same-edge mark wins.
  always_comb begin
    busy_nxt = busy;
    if (we_p1) busy_nxt[a3_p1] = 1'b0;
    if (mark_i && (mark_addr_i != ADDR_ZERO)) busy_nxt[mark_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Address 4 reads the interrupt view, so it never stalls decode.
  always_comb begin
    busy1_o = busy[q1_addr_i] && (q1_addr_i != ADDR_ZERO) && (q1_addr_i != ADDR_IRQ);
    busy2_o = busy[q2_addr_i] && (q2_addr_i != ADDR_ZERO) && (q2_addr_i != ADDR_IRQ);
    idle_o  = (busy == '0) && !we_p1;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin, x0, scoreboard, reset.
module tb_regfile_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        a_valid_i, b_valid_i, mark_i;
  logic        a_ready_o, b_ready_o;
  logic [4:0]  a_addr_i, b_addr_i, mark_addr_i, q1_addr_i, q2_addr_i;
  logic [31:0] a_data_i, b_data_i;
  logic        busy1_o, busy2_o, we3_o, idle_o;
  logic [4:0]  a3_o;
  logic [31:0] wd3_o;

  int checks = 0;
  int errors = 0;
  int a_cnt, b_cnt;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADR_WIDTH(5)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .a_valid_i   (a_valid_i),
    .a_ready_o   (a_ready_o),
    .a_addr_i    (a_addr_i),
    .a_data_i    (a_data_i),
    .b_valid_i   (b_valid_i),
    .b_ready_o   (b_ready_o),
    .b_addr_i    (b_addr_i),
    .b_data_i    (b_data_i),
    .mark_i      (mark_i),
    .mark_addr_i (mark_addr_i),
    .q1_addr_i   (q1_addr_i),
    .q2_addr_i   (q2_addr_i),
    .busy1_o     (busy1_o),
    .busy2_o     (busy2_o),
    .we3_o       (we3_o),
    .a3_o        (a3_o),
    .wd3_o       (wd3_o),
    .idle_o      (idle_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    rst_ni = 1'b0;
    a_valid_i = 1'b1; b_valid_i = 1'b1; mark_i = 1'b0;
    a_addr_i = 5'd3; b_addr_i = 5'd6; mark_addr_i = '0;
    a_data_i = '0; b_data_i = '0; q1_addr_i = 5'd0; q2_addr_i = 5'd0;

    // Reset state: readies low even with both requests valid.
    #3;
    chk("rst_a_ready", a_ready_o, 0);
    chk("rst_b_ready", b_ready_o, 0);
    chk("rst_we3", we3_o, 0);
    chk("rst_a3", a3_o, 0);
    chk("rst_wd3", wd3_o, 0);
    chk("rst_idle", idle_o, 1);
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    #9 rst_ni = 1'b1;

    // Single port A write x5.
    tick();
    a_valid_i = 1'b1; a_addr_i = 5'd5; a_data_i = 32'hDEADBEEF;
    #1;
    chk("single_a_ready", a_ready_o, 1);
    chk("single_b_ready", b_ready_o, 0);
    tick();
    a_valid_i = 1'b0;
    chk("single_we3", we3_o, 1);
    chk("single_a3", a3_o, 5);
    chk("single_wd3", wd3_o, 32'hDEADBEEF);
    tick();
    chk("single_we3_off", we3_o, 0);
    chk("single_a3_hold", a3_o, 5);
    chk("single_wd3_hold", wd3_o, 32'hDEADBEEF);

    // Contention from a fresh reset: A,B,A,B.
    rst_ni = 1'b0; #1 rst_ni = 1'b1;
    a_valid_i = 1'b1; a_addr_i = 5'd1; a_data_i = 32'h11;
    b_valid_i = 1'b1; b_addr_i = 5'd2; b_data_i = 32'h22;
    a_cnt = 0; b_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_a_ready", a_ready_o, (i % 2 == 0) ? 1 : 0);
      chk("cont_b_ready", b_ready_o, (i % 2 == 0) ? 0 : 1);
      a_cnt += int'(a_ready_o);
      b_cnt += int'(b_ready_o);
      tick();
      chk("cont_we3", we3_o, 1);
      chk("cont_a3", a3_o, (i % 2 == 0) ? 5'd1 : 5'd2);
      chk("cont_wd3", wd3_o, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    chk("cont_a_cnt", a_cnt, 2);
    chk("cont_b_cnt", b_cnt, 2);

    // x0 write via B plus a mark to x0.
    b_valid_i = 1'b1; b_addr_i = 5'd0; b_data_i = 32'h1234;
    mark_i = 1'b1; mark_addr_i = 5'd0; q1_addr_i = 5'd0;
    #1;
    chk("x0_b_ready", b_ready_o, 1);
    tick();
    b_valid_i = 1'b0; mark_i = 1'b0;
    chk("x0_we3", we3_o, 0);
    chk("x0_busy1", busy1_o, 0);
    chk("x0_idle", idle_o, 1);

    // Scoreboard: mark x7, cleared on the commit edge.
    mark_i = 1'b1; mark_addr_i = 5'd7;
    tick();
    mark_i = 1'b0; q1_addr_i = 5'd7;
    #1;
    chk("sb_busy_set", busy1_o, 1);
    chk("sb_not_idle", idle_o, 0);
    a_valid_i = 1'b1; a_addr_i = 5'd7; a_data_i = 32'h77;
    tick();
    a_valid_i = 1'b0;
    chk("sb_we3", we3_o, 1);
    chk("sb_a3", a3_o, 7);
    chk("sb_busy_pre_clear", busy1_o, 1);
    tick();
    chk("sb_busy_cleared", busy1_o, 0);

    // Same-edge mark and clear of x7: mark wins.
    mark_i = 1'b1; mark_addr_i = 5'd7;
    tick();
    mark_i = 1'b0;
    a_valid_i = 1'b1;
    tick();
    a_valid_i = 1'b0;
    chk("sb_same_we3", we3_o, 1);
    mark_i = 1'b1; mark_addr_i = 5'd7;
    tick();
    mark_i = 1'b0;
    chk("sb_same_busy", busy1_o, 1);
    chk("sb_same_we3_off", we3_o, 0);
    a_valid_i = 1'b1;
    tick();
    a_valid_i = 1'b0;
    tick();
    chk("sb_same_cleared", busy1_o, 0);

    // x4 query is masked even though the bit is stored.
    mark_i = 1'b1; mark_addr_i = 5'd4;
    tick();
    mark_i = 1'b0; q2_addr_i = 5'd4;
    #1;
    chk("irq_busy2", busy2_o, 0);
    chk("irq_not_idle", idle_o, 0);
    a_valid_i = 1'b1; a_addr_i = 5'd4; a_data_i = 32'h44;
    tick();
    a_valid_i = 1'b0;
    tick();
    chk("irq_idle", idle_o, 1);

    // Mid-operation asynchronous reset.
    a_valid_i = 1'b1; a_addr_i = 5'd9; a_data_i = 32'h99;
    mark_i = 1'b1; mark_addr_i = 5'd9; q1_addr_i = 5'd9;
    tick();
    a_valid_i = 1'b0; mark_i = 1'b0;
    chk("mid_we3", we3_o, 1);
    chk("mid_busy1", busy1_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("mid_rst_we3", we3_o, 0);
    chk("mid_rst_busy1", busy1_o, 0);
    chk("mid_rst_idle", idle_o, 1);
    #1 rst_ni = 1'b1;

    // Starvation: B held, A asserted every cycle; B granted on second cycle.
    tick();
    a_valid_i = 1'b1; a_addr_i = 5'd10; a_data_i = 32'hA;
    b_valid_i = 1'b1; b_addr_i = 5'd11; b_data_i = 32'hB;
    #1;
    chk("starve_c0_a", a_ready_o, 1);
    chk("starve_c0_b", b_ready_o, 0);
    tick();
    chk("starve_c1_b", b_ready_o, 1);
    chk("starve_c1_a", a_ready_o, 0);
    tick();
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    chk("starve_b_write", a3_o, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
